// File: rtl/debug_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : debug_capture_buffer
// Description : Snapshot buffer ahead of the debug serializer. On an arm
//               request it records NUM_OF_SAMPLES strobed samples into RAM.
//               It then replays them: one data_valid start pulse, then each
//               sample held for SIZE_OF_SAMPLE clocks.
// Ports       : clk, reset (sync, active-high)
//               sample_in / sample_valid : strobed signed audio samples
//               arm                      : capture request (IDLE only)
//               data_valid / data        : serializer start pulse / word
//               busy / done              : activity flag / last-cycle pulse
// Options     : DEBUG_CAPTURE_THRESHOLD_EN - when defined, capture starts on
//               the first sample with |sample_in| >= THRESHOLD; otherwise it
//               starts on the first strobe after arm.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_capture_buffer #(
    parameter int NUM_OF_SAMPLES = 1024,
    parameter int SIZE_OF_SAMPLE = 16,
    parameter int THRESHOLD      = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SIZE_OF_SAMPLE-1:0] sample_in,
    input  logic                      sample_valid,
    input  logic                      arm,
    output logic                      data_valid,
    output logic [SIZE_OF_SAMPLE-1:0] data,
    output logic                      busy,
    output logic                      done
);

    localparam int c_AW = $clog2(NUM_OF_SAMPLES);
    localparam int c_PW = $clog2(SIZE_OF_SAMPLE * NUM_OF_SAMPLES);
    localparam int c_BW = $clog2(SIZE_OF_SAMPLE);

    localparam logic [c_AW-1:0] c_LAST_IDX = c_AW'(NUM_OF_SAMPLES - 1);
    localparam logic [c_PW-1:0] c_LAST_PB  = c_PW'(SIZE_OF_SAMPLE * NUM_OF_SAMPLES - 1);
    localparam logic [c_PW-1:0] c_DONE_PB  = c_PW'(SIZE_OF_SAMPLE * NUM_OF_SAMPLES - 2);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(SIZE_OF_SAMPLE - 1);
    localparam logic [c_BW-1:0] c_BIT_PRE  = c_BW'(SIZE_OF_SAMPLE - 2);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_PREFETCH = 3'd3,
        ST_PLAYBACK = 3'd4
    } state_t;

    state_t                    r_state;
    logic [SIZE_OF_SAMPLE-1:0] r_mem [NUM_OF_SAMPLES];
    logic [c_AW-1:0]           r_wr_idx;
    logic [c_AW-1:0]           r_rd_idx;
    logic [c_PW-1:0]           r_pb_cnt;
    logic [c_BW-1:0]           r_bit_cnt;
    logic [SIZE_OF_SAMPLE-1:0] r_data;
    logic                      r_data_valid;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_trig;
    logic                      w_we;

    // ------------------------------------------------------------------
    // Trigger qualification
    // ------------------------------------------------------------------
`ifdef DEBUG_CAPTURE_THRESHOLD_EN
    // One extra bit so the most negative sample has a representable magnitude.
    localparam logic [SIZE_OF_SAMPLE:0] c_THRESHOLD = (SIZE_OF_SAMPLE + 1)'(THRESHOLD);
    logic [SIZE_OF_SAMPLE:0] w_ext;
    logic [SIZE_OF_SAMPLE:0] w_mag;
    assign w_ext  = {sample_in[SIZE_OF_SAMPLE-1], sample_in};
    assign w_mag  = w_ext[SIZE_OF_SAMPLE] ? (~w_ext + 1'b1) : w_ext;
    assign w_trig = (w_mag >= c_THRESHOLD);
`else
    assign w_trig = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Capture RAM write port. r_wr_idx is 0 while ARMED, so the triggering
    // sample lands at address 0.
    // ------------------------------------------------------------------
    assign w_we = !reset && sample_valid &&
                  (((r_state == ST_ARMED) && w_trig) || (r_state == ST_CAPTURE));

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_idx] <= sample_in;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM. r_data is the registered RAM read port; it is loaded
    // only on sample boundaries so each word stays stable for its slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_pb_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_state <= ST_ARMED;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (sample_valid && w_trig) begin
                        r_wr_idx <= c_AW'(1);
                        r_state  <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        if (r_wr_idx == c_LAST_IDX) begin
                            r_wr_idx <= '0;
                            r_state  <= ST_PREFETCH;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                ST_PREFETCH: begin
                    // r_rd_idx is 0 here: sample 0 is ready on the first
                    // playback cycle together with the start pulse.
                    r_data       <= r_mem[r_rd_idx];
                    r_data_valid <= 1'b1;
                    r_pb_cnt     <= '0;
                    r_bit_cnt    <= '0;
                    r_state      <= ST_PLAYBACK;
                end
                ST_PLAYBACK: begin
                    r_pb_cnt  <= r_pb_cnt + 1'b1;
                    r_bit_cnt <= (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
                    // Address of the next sample is set up one cycle before
                    // the boundary; the read itself lands on the boundary.
                    if (r_bit_cnt == c_BIT_PRE) begin
                        r_rd_idx <= r_rd_idx + 1'b1;
                    end
                    if (r_bit_cnt == c_BIT_LAST) begin
                        r_data <= r_mem[r_rd_idx];
                    end
                    if (r_pb_cnt == c_DONE_PB) begin
                        r_done <= 1'b1;
                    end
                    if (r_pb_cnt == c_LAST_PB) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_data    <= '0;
                        r_rd_idx  <= '0;
                        r_pb_cnt  <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_valid = r_data_valid;
    assign data       = r_data;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: doc/debug_capture_buffer.md
# debug_capture_buffer

Snapshot buffer sitting directly upstream of the TM4C123GH6PM debug serializer. On an `arm` request it records `NUM_OF_SAMPLES` consecutive strobed audio samples from the vocoder pipeline into on-chip RAM. It then replays them with the serializer's framing: one `data_valid` start pulse, then each sample held stable for exactly `SIZE_OF_SAMPLE` clocks, so the serializer shifts the whole snapshot out MSB-first.

## Interface

Parameters:
- `NUM_OF_SAMPLES`, 1024: samples per snapshot; power of two, ≥2.
- `SIZE_OF_SAMPLE`, 16: sample width in bits; also the hold time per sample in playback.
- `THRESHOLD`, 1024: unsigned magnitude trigger level; used only with `DEBUG_CAPTURE_THRESHOLD_EN`.

Ports:
- `clk`: input, 1 bit. Single clock; all logic on its rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `sample_in`: input, `SIZE_OF_SAMPLE` bits. Signed two's-complement audio sample.
- `sample_valid`: input, 1 bit. One-cycle strobe; `sample_in` is valid in that cycle.
- `arm`: input, 1 bit. Start-capture request; level-sampled each clock.
- `data_valid`: output, 1 bit. One-cycle start pulse to the serializer.
- `data`: output, `SIZE_OF_SAMPLE` bits. Sample currently presented to the serializer.
- `busy`: output, 1 bit. High in every state except IDLE.
- `done`: output, 1 bit. One-cycle pulse on the last playback cycle.

## Operation

- States: IDLE, ARMED, CAPTURE, PREFETCH, PLAYBACK.
- Reset values (any state, including mid-capture or mid-playback): state IDLE, write/read index 0, `data_valid`=0, `data`=0, `busy`=0, `done`=0. RAM contents are not cleared.
- IDLE: `arm`=1 moves to ARMED. A `sample_valid` in the same cycle as `arm` is not stored.
- ARMED: moves to CAPTURE on the trigger condition (see Configuration). The triggering sample is stored at address 0 and the write index becomes 1.
- CAPTURE: each `sample_valid` writes `sample_in` to `mem[wr_idx]` and increments `wr_idx`. The write of index `NUM_OF_SAMPLES-1` moves to PREFETCH. Non-strobed cycles leave state unchanged.
- PREFETCH: one cycle. Issues a read of `mem[0]`, then moves to PLAYBACK.
- PLAYBACK: runs exactly `SIZE_OF_SAMPLE*NUM_OF_SAMPLES` cycles, counted by `pb_cnt` from 0.
  - `data` = `mem[pb_cnt / SIZE_OF_SAMPLE]`. The read for sample k+1 is issued at `pb_cnt % SIZE_OF_SAMPLE == SIZE_OF_SAMPLE-2` so `data` changes exactly on the boundary.
  - `data_valid`=1 only at `pb_cnt`=0.
  - `done`=1 at `pb_cnt`=`SIZE_OF_SAMPLE*NUM_OF_SAMPLES-1`; next state IDLE with `data` returned to 0.
- `arm` is ignored in every non-IDLE state. `sample_valid` is ignored in IDLE, PREFETCH and PLAYBACK; those samples are dropped.
- Counter widths: `wr_idx` is `$clog2(NUM_OF_SAMPLES)` bits; `pb_cnt` is `$clog2(SIZE_OF_SAMPLE*NUM_OF_SAMPLES)` bits. Neither ever wraps within a snapshot.
- RAM: single-port-write, single-port-read, registered read (one-cycle latency), inferable as block RAM.

## Timing

- `data_valid` is asserted the cycle after PREFETCH. At that cycle `data` already equals `mem[0]`.
- Sample k is presented during PLAYBACK cycles `k*SIZE_OF_SAMPLE` through `k*SIZE_OF_SAMPLE+SIZE_OF_SAMPLE-1`.
- Latency from the final capture strobe to `data_valid`: 2 clocks (PREFETCH, then the first PLAYBACK cycle).
- Back-to-back snapshots: `arm` is accepted no earlier than the cycle after `done`.
- All outputs are registered.

## Configuration

- `DEBUG_CAPTURE_THRESHOLD_EN` defined: ARMED waits for a `sample_valid` with |`sample_in`| ≥ `THRESHOLD`.
  - Magnitude is computed in `SIZE_OF_SAMPLE+1` bits, so the most negative value (-32768 at 16 bits) has magnitude 32768 and never overflows.
  - Samples below the threshold are discarded.
- Not defined: the first `sample_valid` in ARMED triggers unconditionally, and `THRESHOLD` is unused.

## Test plan

Bench uses NUM_OF_SAMPLES=4, SIZE_OF_SAMPLE=16, sample strobes every 5 clocks.

- Basic capture/playback (macro off): pulse `arm`, feed 0x1111, 0x2222, 0x3333, 0x4444.
  - Expect `data_valid` 2 clocks after the 4th strobe.
  - Expect `data` to hold each value for 16 clocks in order.
  - Expect `done` at playback cycle 63, then `busy`=0.
- `arm` coincident with `sample_valid` (0x7777) in IDLE: 0x7777 is not captured; the first stored sample is the next strobe.
- Threshold (macro on, THRESHOLD=1024): feed 100, -500, -1024, 5, 6, 7.
  - Capture starts at -1024 (0xFC00).
  - Playback is 0xFC00, 0x0005, 0x0006, 0x0007.
  - With input -32768 (0x8000), the trigger fires.
- Ignored inputs: `arm` pulses and `sample_valid` strobes during CAPTURE and PLAYBACK cause no restart and no extra writes. Playback data is unchanged.
- Reset mid-playback at cycle 20: the next cycle shows `data`=0, `data_valid`=0, `busy`=0. A fresh `arm` then completes normally.
